// File: rtl/layer_output_serializer.sv
// layer_output_serializer
// Captures a fully-connected layer's parallel neuron outputs when every valid
// bit is high, then replays them one word per clock with valid/last flags.
// Vectors that arrive while a vector is still being sent are dropped and
// reported through the sticky overrun flag.
module layer_output_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overrun
);

  // The counter needs at least one bit even for a single-word vector.
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NN*dataWidth-1:0] shreg_q, shreg_d;
  logic [dataWidth-1:0]    o_data_q, o_data_d;
  logic                    o_valid_q, o_valid_d;
  logic                    o_last_q, o_last_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    cap;

  // A capture needs every neuron valid in the same cycle; partial patterns are ignored.
  assign cap = &i_valid;

  // Next-state logic: capture/reload, word stepping, and overrun detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_last_d  = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (cap) begin
          // Word 0 goes straight to the output; the rest wait in the shift register.
          shreg_d   = i_data >> dataWidth;
          o_data_d  = i_data[dataWidth-1:0];
          o_valid_d = 1'b1;
          cnt_d     = '0;
          o_last_d  = (NN == 1);
          busy_d    = 1'b1;
          state_d   = SEND;
        end else begin
          busy_d = 1'b0;
        end
      end

      SEND: begin
        if (cnt_q != LAST_CNT) begin
          // Mid-vector: a new capture cannot be accepted, so it is dropped and flagged.
          o_data_d  = shreg_q[dataWidth-1:0];
          shreg_d   = shreg_q >> dataWidth;
          cnt_d     = cnt_q + CW'(1);
          o_valid_d = 1'b1;
          o_last_d  = ((cnt_q + CW'(1)) == LAST_CNT);
          if (cap) begin
            overrun_d = 1'b1;
          end
        end else if (cap) begin
          // Final word is on the output, so a new vector follows with no idle bubble.
          shreg_d   = i_data >> dataWidth;
          o_data_d  = i_data[dataWidth-1:0];
          o_valid_d = 1'b1;
          cnt_d     = '0;
          o_last_d  = (NN == 1);
          busy_d    = 1'b1;
          state_d   = SEND;
        end else begin
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// tb_layer_output_serializer
// Scoreboard bench: expected words are queued as vectors are driven and are
// popped when the serializer presents them. A second instance covers NN=1.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic              clk;
  logic              rst;
  logic [NN-1:0]     i_valid;
  logic [NN*DW-1:0]  i_data;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic              busy;
  logic              overrun;

  logic              i_valid1;
  logic [DW-1:0]     i_data1;
  logic              o_valid1;
  logic [DW-1:0]     o_data1;
  logic              o_last1;
  logic              busy1;
  logic              overrun1;

  logic [DW:0]       exp_q[$];
  logic [DW:0]       exp1_q[$];
  logic [DW:0]       exp_word;

  int tests;
  int fails;

  layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .busy    (busy),
    .overrun (overrun)
  );

  layer_output_serializer #(.NN(1), .dataWidth(DW)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid1),
    .i_data  (i_data1),
    .o_valid (o_valid1),
    .o_data  (o_data1),
    .o_last  (o_last1),
    .busy    (busy1),
    .overrun (overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the NN=4 instance: every valid word must match the queue head.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb4_unexpected: got word %h last %b, required no word", o_data, o_last);
      end else begin
        exp_word = exp_q.pop_front();
        if ({o_last, o_data} !== exp_word) begin
          fails++;
          $display("[TB] FAIL sb4_word: got data %h last %b, required data %h last %b",
                   o_data, o_last, exp_word[DW-1:0], exp_word[DW]);
        end
      end
    end
  end

  // Scoreboard for the NN=1 instance.
  always @(negedge clk) begin
    if (!rst && o_valid1) begin
      tests++;
      if (exp1_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb1_unexpected: got word %h last %b, required no word", o_data1, o_last1);
      end else if ({o_last1, o_data1} !== exp1_q[0]) begin
        fails++;
        $display("[TB] FAIL sb1_word: got data %h last %b, required data %h last %b",
                 o_data1, o_last1, exp1_q[0][DW-1:0], exp1_q[0][DW]);
        void'(exp1_q.pop_front());
      end else begin
        void'(exp1_q.pop_front());
      end
    end
  end

  function automatic logic [NN*DW-1:0] make_vec(input int base);
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  // Drive one cycle of inputs and return at the following negedge.
  task automatic apply_cycle(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
    i_valid = v;
    i_data  = d;
    @(negedge clk);
  endtask

  task automatic push_vec(input int base);
    for (int k = 0; k < NN; k++) exp_q.push_back({(k == NN - 1), DW'(base + k)});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_valid = '0; i_data = '0; i_valid1 = 1'b0; i_data1 = '0;
    #12;
    tests++;
    if ({o_valid, o_last, busy, overrun} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got v/l/b/o %b, required 0000", {o_valid, o_last, busy, overrun});
    end
    tests++;
    if (o_data !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h, required 0000", o_data);
    end
    tests++;
    if ({o_valid1, o_last1, busy1, overrun1, o_data1} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_nn1: got %b_%h, required all zero",
               {o_valid1, o_last1, busy1, overrun1}, o_data1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_vector;
    push_vec(1);
    apply_cycle(4'hF, make_vec(1));
    for (int k = 0; k < NN; k++) begin
      tests++;
      if ({o_valid, busy} !== 2'b11) begin
        fails++;
        $display("[TB] FAIL single_busy_w%0d: got valid/busy %b, required 11", k, {o_valid, busy});
      end
      if (k < NN - 1) apply_cycle('0, '0);
    end
    apply_cycle('0, '0);
    tests++;
    if ({o_valid, o_last, busy, overrun} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL single_idle: got v/l/b/o %b, required 0000", {o_valid, o_last, busy, overrun});
    end
    tests++;
    if (o_data !== 16'h0004) begin
      fails++;
      $display("[TB] FAIL single_hold: got o_data %h, required 0004", o_data);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL single_drained: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_partial_valid;
    for (int c = 0; c < 10; c++) begin
      apply_cycle(4'h7, make_vec(20));
      tests++;
      if ({o_valid, busy, overrun} !== 3'b000) begin
        fails++;
        $display("[TB] FAIL partial_c%0d: got v/b/o %b, required 000", c, {o_valid, busy, overrun});
      end
    end
    apply_cycle('0, '0);
  endtask

  task automatic test_back_to_back;
    push_vec(1);
    apply_cycle(4'hF, make_vec(1));
    for (int c = 0; c < 2 * NN - 1; c++) begin
      if (c == NN - 1) begin
        push_vec(5);
        apply_cycle(4'hF, make_vec(5));
      end else begin
        apply_cycle('0, '0);
      end
      tests++;
      if ({o_valid, busy, overrun} !== 3'b110) begin
        fails++;
        $display("[TB] FAIL b2b_c%0d: got v/b/o %b, required 110", c, {o_valid, busy, overrun});
      end
    end
    apply_cycle('0, '0);
    tests++;
    if ({o_valid, busy, overrun} !== 3'b000 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL b2b_end: got v/b/o %b pending %0d, required 000 pending 0",
               {o_valid, busy, overrun}, exp_q.size());
    end
  endtask

  task automatic test_overrun;
    push_vec(1);
    apply_cycle(4'hF, make_vec(1));
    apply_cycle('0, '0);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overrun_pre: got %b, required 0", overrun);
    end
    apply_cycle(4'hF, make_vec(9));
    tests++;
    if ({overrun, busy} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL overrun_set: got overrun/busy %b, required 11", {overrun, busy});
    end
    apply_cycle('0, '0);
    apply_cycle('0, '0);
    tests++;
    if ({o_valid, busy} !== 2'b00 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL overrun_finish: got v/b %b pending %0d, required 00 pending 0",
               {o_valid, busy}, exp_q.size());
    end
    for (int c = 0; c < 20; c++) apply_cycle('0, '0);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_transfer;
    push_vec(1);
    apply_cycle(4'hF, make_vec(1));
    apply_cycle('0, '0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({o_valid, o_last, busy, overrun} !== 4'b0000 || o_data !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_async: got v/l/b/o %b data %h, required 0000 data 0000",
               {o_valid, o_last, busy, overrun}, o_data);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      apply_cycle('0, '0);
      tests++;
      if ({o_valid, busy} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL midreset_quiet_c%0d: got v/b %b, required 00", c, {o_valid, busy});
      end
    end
  endtask

  task automatic test_nn1;
    exp1_q.push_back({1'b1, 16'hABCD});
    i_valid1 = 1'b1;
    i_data1  = 16'hABCD;
    @(negedge clk);
    i_valid1 = 1'b0;
    i_data1  = '0;
    tests++;
    if ({o_valid1, busy1} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL nn1_word: got v/b %b, required 11", {o_valid1, busy1});
    end
    @(negedge clk);
    tests++;
    if ({o_valid1, o_last1, busy1} !== 3'b000 || exp1_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL nn1_end: got v/l/b %b pending %0d, required 000 pending 0",
               {o_valid1, o_last1, busy1}, exp1_q.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_single_vector;
    test_partial_valid;
    test_back_to_back;
    test_overrun;
    test_reset_mid_transfer;
    test_nn1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
